// File: rtl/ct_fifo_rr_sched_pkg.sv
// rtl/ct_fifo_rr_sched_pkg.sv - shared state encodings and payload constants for ct_fifo_rr_sched
package ct_fifo_rr_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } sched_state_e;

  localparam int DEF_WIDTH = 6;
  // Burst "last" flag position within a payload of DEF_WIDTH bits
  localparam int LAST_BIT  = DEF_WIDTH - 1;

endpackage

// File: rtl/ct_rr_prio_sel.sv
// rtl/ct_rr_prio_sel.sv - one-hot round-robin priority select starting at a one-hot pointer
// Ports: req_i request vector, ptr_i one-hot start position, grant_o one-hot grant (zero if no request)
module ct_rr_prio_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] grant_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] first;

  always_comb begin
    // Lower copy keeps only requests at or above the pointer; the upper copy
    // supplies the wrapped-around requests. The lowest set bit wins.
    dbl     = {req_i, req_i & ~(ptr_i - N'(1))};
    first   = dbl & ~(dbl - (2*N)'(1));
    grant_o = first[N-1:0] | first[2*N-1:N];
  end

endmodule

// File: rtl/ct_fifo_rr_sched.sv
// rtl/ct_fifo_rr_sched.sv - round-robin pop scheduler draining several ct_fifo sources into one output stage
// Ports: src_empty/src_data/src_mask from the source FIFOs, src_pop_en pop strobes back to them,
//        out_vld/out_data/out_src/out_rdy registered downstream handshake, sched_flush drops the
//        output beat and any lock, sched_busy reports a held beat or lock.
module ct_fifo_rr_sched
  import ct_fifo_rr_sched_pkg::*;
#(
  parameter int SRC_NUM = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SRC_W   = 2,
  parameter int LOCK_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SRC_NUM-1:0]       src_empty,
  input  logic [SRC_NUM*WIDTH-1:0] src_data,
  input  logic [SRC_NUM-1:0]       src_mask,
  output logic [SRC_NUM-1:0]       src_pop_en,
  output logic                     out_vld,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_rdy,
  input  logic                     sched_flush,
  output logic                     sched_busy
);

  localparam int LAST = WIDTH - 1;

  sched_state_e       state_q;
  logic [SRC_W-1:0]   lock_q;
  logic [SRC_NUM-1:0] rr_ptr_q;
  logic [SRC_NUM-1:0] rr_ptr_d;
  logic               out_vld_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SRC_W-1:0]   out_src_q;

  logic [SRC_NUM-1:0] lock_oh;
  logic [SRC_NUM-1:0] req;
  logic [SRC_NUM-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   grant_data;
  logic               grant_last;
  logic               load;
  logic               ends_arb;

  always_comb begin
    lock_oh   = '0;
    grant_idx = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      lock_oh[i] = (lock_q == SRC_W'(i));
      if (grant[i]) grant_idx = SRC_W'(i);
    end
  end

  // While locked only the locked source may win, regardless of its mask bit
  assign req = (state_q == ST_LOCK) ? (~src_empty & lock_oh) : (~src_empty & src_mask);

  ct_rr_prio_sel #(.N(SRC_NUM)) u_sel (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant)
  );

  assign grant_data = src_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign grant_last = grant_data[LAST];
  assign load       = ~sched_flush & (~out_vld_q | out_rdy) & (|grant);
  assign ends_arb   = load & ((LOCK_EN == 0) | grant_last);
  assign rr_ptr_d   = ends_arb ? {grant[SRC_NUM-2:0], grant[SRC_NUM-1]} : rr_ptr_q;

  // Pop in the same cycle the entry is captured, so the FIFO head is consumed exactly once
  assign src_pop_en = rst ? '0 : (grant & {SRC_NUM{load}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_q     <= '0;
      rr_ptr_q   <= SRC_NUM'(1);
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (sched_flush) begin
        out_vld_q <= 1'b0;
        state_q   <= ST_IDLE;
      end else begin
        if (load) begin
          out_data_q <= grant_data;
          out_src_q  <= grant_idx;
          out_vld_q  <= 1'b1;
        end else if (out_rdy) begin
          out_vld_q <= 1'b0;
        end
        case (state_q)
          ST_IDLE: if (load && (LOCK_EN != 0) && !grant_last) begin
            state_q <= ST_LOCK;
            lock_q  <= grant_idx;
          end
          ST_LOCK: if (load && grant_last) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign sched_busy = out_vld_q | (state_q == ST_LOCK);

endmodule

// File: tb/tb_ct_fifo_rr_sched.sv
// tb/tb_ct_fifo_rr_sched.sv - directed self-checking bench for ct_fifo_rr_sched
module tb_ct_fifo_rr_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  src_empty;
  logic [23:0] src_data;
  logic [3:0]  src_mask;
  logic        out_rdy;
  logic        sched_flush;

  logic [3:0]  pop0, pop1;
  logic        vld0, vld1, busy0, busy1;
  logic [5:0]  data0, data1;
  logic [1:0]  src0, src1;

  int checks = 0;
  int errors = 0;

  logic [5:0] qm [4][16];
  int         qh [4];
  int         qt [4];
  bit         use0;

  ct_fifo_rr_sched #(.SRC_NUM(4), .WIDTH(6), .SRC_W(2), .LOCK_EN(0)) dut0 (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_data(src_data), .src_mask(src_mask),
    .src_pop_en(pop0), .out_vld(vld0), .out_data(data0), .out_src(src0), .out_rdy(out_rdy),
    .sched_flush(sched_flush), .sched_busy(busy0)
  );

  ct_fifo_rr_sched #(.SRC_NUM(4), .WIDTH(6), .SRC_W(2), .LOCK_EN(1)) dut1 (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_data(src_data), .src_mask(src_mask),
    .src_pop_en(pop1), .out_vld(vld1), .out_data(data1), .out_src(src1), .out_rdy(out_rdy),
    .sched_flush(sched_flush), .sched_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] mk(input bit l, input int s, input int b);
    return {l, s[1:0], b[2:0]};
  endfunction

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      src_empty[i]      = (qh[i] == qt[i]);
      src_data[i*6 +: 6] = (qh[i] == qt[i]) ? 6'd0 : qm[i][qh[i]];
    end
  endtask

  task automatic push(input int s, input logic [5:0] d);
    qm[s][qt[s]] = d;
    qt[s]++;
  endtask

  task automatic drive();
    refresh();
    #1;
  endtask

  task automatic adv();
    logic [3:0] p;
    p = use0 ? pop0 : pop1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (p[i] && qh[i] < qt[i]) qh[i]++;
    refresh();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_rdy = 1'b1;
    sched_flush = 1'b0;
    src_mask = 4'hF;
    use0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    refresh();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int seq6 [6];
    seq6 = '{0, 1, 3, 0, 1, 3};

    do_reset();
    check("rst_vld", vld1, 0);
    check("rst_data", data1, 0);
    check("rst_src", src1, 0);
    check("rst_busy", busy1, 0);
    check("rst_pop", pop1, 0);
    check("rst_vld0", vld0, 0);

    // Sources 0 and 2, one last beat each
    push(0, mk(1, 0, 1));
    push(2, mk(1, 2, 1));
    drive();
    check("t1_pop_a", pop1, 4'b0001);
    check("t1_pop_a0", pop0, 4'b0001);
    adv();
    check("t1_vld", vld1, 1);
    check("t1_src_a", src1, 0);
    check("t1_data_a", data1, mk(1, 0, 1));
    check("t1_src_a0", src0, 0);
    check("t1_pop_b", pop1, 4'b0100);
    adv();
    check("t1_src_b", src1, 2);
    check("t1_data_b", data1, mk(1, 2, 1));
    check("t1_src_b0", src0, 2);
    check("t1_pop_none", pop1, 0);
    adv();
    check("t1_drain", vld1, 0);
    // Pointer should now sit at source 3
    for (int s = 0; s < 4; s++) push(s, mk(1, s, 2));
    drive();
    for (int k = 0; k < 4; k++) begin
      int e;
      e = (3 + k) % 4;
      check("t1_rr_pop", pop1, 1 << e);
      adv();
      check("t1_rr_src", src1, e);
      check("t1_rr_src0", src0, e);
    end

    // All sources continuously non-empty, last beats
    do_reset();
    for (int s = 0; s < 4; s++) begin
      push(s, mk(1, s, 0));
      push(s, mk(1, s, 1));
    end
    drive();
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      check("t2_pop", pop1, 1 << e);
      adv();
      check("t2_src", src1, e);
      check("t2_src0", src0, e);
      check("t2_vld", vld1, 1);
      check("t2_data", data1, mk(1, e, k / 4));
    end

    // No lock: non-last beats still rotate
    do_reset();
    use0 = 1'b1;
    push(1, mk(0, 1, 0));
    push(3, mk(0, 3, 0));
    push(1, mk(0, 1, 1));
    drive();
    check("t0_pop_a", pop0, 4'b0010);
    adv();
    check("t0_src_a", src0, 1);
    check("t0_pop_b", pop0, 4'b1000);
    adv();
    check("t0_src_b", src0, 3);
    check("t0_pop_c", pop0, 4'b0010);
    adv();
    check("t0_src_c", src0, 1);
    check("t0_data_c", data0, mk(0, 1, 1));

    // Lock on source 1 with two bubble cycles mid-burst
    do_reset();
    push(1, mk(0, 1, 0));
    push(3, mk(1, 3, 0));
    drive();
    check("t3_pop_a", pop1, 4'b0010);
    adv();
    check("t3_src_a", src1, 1);
    check("t3_busy_a", busy1, 1);
    check("t3_bubble1", pop1, 0);
    adv();
    check("t3_vld_bub", vld1, 0);
    check("t3_bubble2", pop1, 0);
    adv();
    check("t3_busy_bub", busy1, 1);
    check("t3_vld_bub2", vld1, 0);
    push(1, mk(0, 1, 1));
    push(1, mk(1, 1, 2));
    drive();
    check("t3_pop_b", pop1, 4'b0010);
    adv();
    check("t3_src_b", src1, 1);
    check("t3_data_b", data1, mk(0, 1, 1));
    check("t3_pop_c", pop1, 4'b0010);
    adv();
    check("t3_src_c", src1, 1);
    check("t3_data_c", data1, mk(1, 1, 2));
    check("t3_pop_d", pop1, 4'b1000);
    adv();
    check("t3_src_d", src1, 3);
    adv();
    check("t3_idle", busy1, 0);

    // Backpressure holds the stage and suppresses pops
    do_reset();
    out_rdy = 1'b0;
    push(0, mk(1, 0, 0));
    push(0, mk(1, 0, 1));
    push(1, mk(1, 1, 0));
    drive();
    check("t4_pop_first", pop1, 4'b0001);
    adv();
    check("t4_vld", vld1, 1);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_pop", pop1, 0);
      check("t4_hold_data", data1, mk(1, 0, 0));
      adv();
    end
    check("t4_hold_src", src1, 0);
    out_rdy = 1'b1;
    drive();
    check("t4_pop_next", pop1, 4'b0010);
    adv();
    check("t4_src_next", src1, 1);
    check("t4_data_next", data1, mk(1, 1, 0));

    // Flush in the middle of a lock
    do_reset();
    push(1, mk(0, 1, 0));
    push(1, mk(0, 1, 1));
    push(1, mk(1, 1, 2));
    push(2, mk(1, 2, 0));
    drive();
    adv();
    check("t5_src", src1, 1);
    check("t5_busy", busy1, 1);
    sched_flush = 1'b1;
    drive();
    check("t5_flush_pop", pop1, 0);
    adv();
    check("t5_flush_vld", vld1, 0);
    check("t5_flush_busy", busy1, 0);
    check("t5_flush_data", data1, mk(0, 1, 0));
    sched_flush = 1'b0;
    drive();
    check("t5_after_pop", pop1, 4'b0010);
    adv();
    check("t5_after_src", src1, 1);
    check("t5_after_data", data1, mk(0, 1, 1));

    // Masked source 2 is skipped, then asynchronous reset mid-stream
    do_reset();
    src_mask = 4'b1011;
    for (int s = 0; s < 4; s++) begin
      push(s, mk(1, s, 0));
      push(s, mk(1, s, 1));
    end
    drive();
    for (int k = 0; k < 6; k++) begin
      check("t6_pop", pop1, 1 << seq6[k]);
      adv();
      check("t6_src", src1, seq6[k]);
    end
    src_mask = 4'hF;
    drive();
    check("t6_unmask_pop", pop1, 4'b0100);
    rst = 1'b1;
    #1;
    check("t6_rst_vld", vld1, 0);
    check("t6_rst_data", data1, 0);
    check("t6_rst_src", src1, 0);
    check("t6_rst_busy", busy1, 0);
    check("t6_rst_pop", pop1, 0);
    check("t6_rst_vld0", vld0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_post_pop", pop1, 4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_fifo_rr_sched.md
# ct_fifo_rr_sched

Round-robin pop scheduler that drains up to SRC_NUM independent ct_fifo instances onto one shared downstream channel. It drives each FIFO's pop enable, registers the selected entry into a single output stage with a valid/ready handshake, and optionally locks the grant on one source for a multi-beat burst. It sits between a bank of per-requester CIU FIFOs and a single consumer such as a bus request or response port.

## Interface
- SRC_NUM, 4, number of source FIFOs (2..8)
- WIDTH, 6, payload width per entry; bit WIDTH-1 is the burst "last" flag
- SRC_W, 2, width of source index, equal to ceil(log2(SRC_NUM))
- LOCK_EN, 1, 1 = hold the grant until a last beat; 0 = re-arbitrate every beat

- clk  input  1  clock; all state on posedge
- rst  input  1  asynchronous, active-high reset
- src_empty  input  SRC_NUM  per-source fifo_empty
- src_data  input  SRC_NUM*WIDTH  per-source fifo_pop_data; source i occupies [i*WIDTH +: WIDTH]
- src_mask  input  SRC_NUM  1 = source eligible for a new grant
- src_pop_en  output  SRC_NUM  one-hot or zero pop strobe, drives fifo_pop_en
- out_vld  output  1  output stage holds a beat
- out_data  output  WIDTH  registered payload
- out_src  output  SRC_W  index of the source of out_data
- out_rdy  input  1  consumer accepts the beat when out_vld & out_rdy
- sched_flush  input  1  synchronous flush of the output stage and the lock
- sched_busy  output  1  out_vld | lock held

## Operation
- Load condition: `load = ~sched_flush & (~out_vld | out_rdy) & (grant != 0)`.
- Eligibility, state IDLE: source i is eligible if `~src_empty[i] & src_mask[i]`.
- Eligibility, state LOCK: only the locked source is eligible, and only if `~src_empty[lock]`. src_mask is ignored for the locked source.
- Grant: the first eligible source searching upward from rr_ptr, with wrap-around.
- Pop: `src_pop_en = grant & {SRC_NUM{load}}`. This is combinational in the same cycle as the load, so src_pop_en is never more than one-hot.
- On load: out_data <= src_data[grant], out_src <= index(grant), out_vld <= 1.
- Else on out_rdy: out_vld <= 0.
- rr_ptr, one-hot:
  - Rotates to grant+1 (mod SRC_NUM) on a load that ends arbitration. That is a load with LOCK_EN=0, or a load whose beat is last.
  - Otherwise rr_ptr is unchanged.
- FSM, IDLE -> LOCK: on a load with LOCK_EN=1 and a non-last beat; the lock index is captured.
- FSM, LOCK -> IDLE: on a load of a last beat from the locked source.
- FSM, LOCK with the locked source empty: a bubble. No pop, and the lock is held.
- sched_flush: out_vld <= 0, FSM -> IDLE, no pop that cycle. rr_ptr and out_data are unchanged. Flush wins over a simultaneous load.

## Timing
- Reset values:
  - out_vld=0, out_data=0, out_src=0, sched_busy=0.
  - src_pop_en=0, forced while rst is high.
  - rr_ptr=source 0, FSM=IDLE.
- Latency: a source going non-empty at edge N gives out_vld=1 after edge N+1.
- Throughput: 1 beat/cycle with out_rdy held high. Holding out_rdy=0 freezes out_data and out_src and issues no pops.
- A popped entry's data is sampled in the same cycle as src_pop_en.
- Reset asserted mid-burst returns the block to the reset state immediately. Source FIFOs are reset separately.

## Structure
- Shared include/package: FSM state encodings (IDLE=1'b0, LOCK=1'b1) and the `LAST_BIT = WIDTH-1` localparam.
- One combinational sub-module, `ct_rr_prio_sel`:
  - Inputs: SRC_NUM request vector and one-hot rr_ptr.
  - Output: one-hot grant.
  - Implemented as a double-width mask-and-priority search.
- Top holds the output register, the FSM, and the rr_ptr and lock registers, with no clock gating.

## Test plan
- Reset, then sources 0 and 2 each non-empty with one last beat, out_rdy=1 -> source 0 popped at cycle 1, source 2 at cycle 2; out_src 0 then 2; rr_ptr ends at 3.
- All 4 sources continuously non-empty with last beats, LOCK_EN=0 -> out_src sequence 0,1,2,3,0, one beat per cycle.
- LOCK_EN=1, source 1 holds a 3-beat burst (last flag on beat 3), source 3 is non-empty -> out_src 1,1,1,3. Source 1 empties for 2 cycles mid-burst -> 2 bubble cycles, and source 3 is not granted.
- out_vld=1 with out_rdy=0 for 5 cycles -> src_pop_en=0 and out_data stable; out_rdy rises -> next beat loads the following cycle.
- sched_flush asserted mid-lock while source 1 is non-empty -> no pop that cycle, out_vld=0, FSM IDLE; next grant follows rr_ptr.
- src_mask=4'b1011 with all sources non-empty -> source 2 is never granted; rst pulse mid-stream -> all outputs return to reset values asynchronously.
